selector41_tdm: RTL and testbench
=================================

SELECTOR41_TDM -- requirements
Module: selector41_tdm

Interface
REQ-001 Parameter DWELL, default 4, SHALL set clock cycles per slot; legal range 1..255.
REQ-002 iClk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 iRst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 iEn  input  1  SHALL request frame transmission; sampled at each frame boundary and in IDLE.
REQ-005 iD0, iD1, iD2, iD3  input  1 each  SHALL be the four channel bits to be time-multiplexed.
REQ-006 oZ  output  1  SHALL be the serial multiplexed data line.
REQ-007 oS1, oS0  output  1 each  SHALL be the current slot index (MSB, LSB), directly usable as select lines by de_selector14.
REQ-008 oValid  output  1  SHALL be high while a frame is being sent.
REQ-009 oFrame  output  1  SHALL pulse high for exactly the first cycle of slot 0 of each frame.

Function
REQ-010 States SHALL be IDLE and SEND only.
REQ-011 IDLE: oZ=0, oS1=0, oS0=0, oValid=0, oFrame=0.
REQ-012 IDLE with iEn=1 at a rising edge SHALL, at that edge, latch {iD3,iD2,iD1,iD0} into a 4-bit frame register, clear slot and dwell counters, and enter SEND.
REQ-013 SEND: oZ SHALL equal the latched bit selected by the slot index (slot 0 -> iD0 ... slot 3 -> iD3); oValid=1.
REQ-014 Inputs iD0..iD3 changing mid-frame SHALL NOT affect oZ until the next latch.
REQ-015 Dwell counter SHALL increment each SEND cycle and wrap to 0 after DWELL-1; on wrap the slot index SHALL increment.
REQ-016 At the last cycle of slot 3 with iEn=1: relatch inputs, slot=0, stay in SEND; frames back-to-back with no gap cycle.
REQ-017 At the last cycle of slot 3 with iEn=0: return to IDLE next cycle.
REQ-018 iEn deasserted mid-frame SHALL NOT abort the frame; the frame SHALL complete all four slots.
REQ-019 Frame length SHALL be exactly 4*DWELL cycles; latency from iEn sampled high in IDLE to first oValid cycle is 1 cycle.
REQ-020 DWELL=1 SHALL advance slot every cycle with no idle or stall cycles.
REQ-021 All outputs SHALL be driven from registers only (no combinational path from inputs to outputs).

Reset
REQ-022 iRst=1 at a rising edge SHALL force IDLE, clear frame register, slot and dwell counters; all outputs 0 in the following cycle.
REQ-023 iRst SHALL override iEn and any in-progress frame; no partial-frame outputs after reset.
REQ-024 After iRst falls, operation SHALL resume per REQ-012 on the next edge with iEn=1.

Structure
REQ-025 Shared package selector_pkg SHALL hold the state encoding (IDLE, SEND) and the constant NUM_SLOTS=4.
REQ-026 The dwell/slot counter pair SHALL be one sub-module, slot_timer, parameterized by DWELL, outputting slot index and a last-cycle-of-slot flag.

Verification
REQ-027 DWELL=4, iD3..iD0=1011, iEn=1 for one cycle then 0 -> oValid high 16 cycles; oZ = 1,1,0,1 per 4-cycle slot; oS = 00,01,10,11; oFrame single pulse.
REQ-028 iEn held 1, inputs 1011 then 0100 changed mid-frame -> first frame serializes 1011 unchanged, second frame serializes 0100 starting with no gap; oFrame pulses 16 cycles apart.
REQ-029 iRst asserted in slot 2 -> next cycle oZ=0, oS=00, oValid=0, oFrame=0; resumes cleanly after iRst low with iEn=1.
REQ-030 DWELL=1, iD=0110, iEn=1 -> oZ sequence 0,1,1,0 over 4 consecutive cycles, oS increments each cycle.
REQ-031 Loopback: oZ, oS1, oS0 into de_selector14 (iC, iS1, iS0) -> oZk equals the latched iDk during slot k, 0 otherwise, for all 16 input patterns.

Source files
------------

// File: rtl/selector41_tdm_pkg.sv
// Shared types and constants for the four-channel TDM selector.
package selector_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 4;
endpackage

// File: rtl/selector41_tdm_if.sv
// Channel inputs and serial/select outputs of the four-to-one TDM selector.
interface selector41_tdm_if;
    logic iEn;
    logic iD0;
    logic iD1;
    logic iD2;
    logic iD3;
    logic oZ;
    logic oS1;
    logic oS0;
    logic oValid;
    logic oFrame;

    modport master (
        output iEn, iD0, iD1, iD2, iD3,
        input  oZ, oS1, oS0, oValid, oFrame
    );

    modport slave (
        input  iEn, iD0, iD1, iD2, iD3,
        output oZ, oS1, oS0, oValid, oFrame
    );
endinterface

// File: rtl/selector41_tdm_slot_timer.sv
// Dwell/slot counter pair: slot advances every DWELL cycles while running.
module slot_timer #(
    parameter int DWELL = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iClear,
    input  logic       iRun,
    output logic [1:0] oSlot,
    output logic       oLast
);
    logic [7:0] dwellCnt;
    logic [1:0] slot;

    assign oLast = (dwellCnt == 8'(DWELL - 1));
    assign oSlot = slot;

    // Slot wraps 3 -> 0 naturally, so back-to-back frames need no extra clear.
    always_ff @(posedge iClk) begin
        if (iRst || iClear) begin
            dwellCnt <= '0;
            slot     <= '0;
        end else if (iRun) begin
            if (oLast) begin
                dwellCnt <= '0;
                slot     <= slot + 2'd1;
            end else begin
                dwellCnt <= dwellCnt + 8'd1;
            end
        end
    end
endmodule

// File: rtl/selector41_tdm.sv
// Four-channel time-division selector: latches a 4-bit frame and serializes it
// one bit per slot, presenting the slot index as select lines.
//   state | meaning
//   IDLE  | outputs low, waiting for iEn to latch a frame
//   SEND  | serializing the latched frame, one bit per DWELL-cycle slot
module selector41_tdm
    import selector_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic                 iClk,
    input  logic                 iRst,
    selector41_tdm_if.slave      bus
);
    state_t     state;
    state_t     nextState;
    logic [3:0] frameReg;
    logic       frameStart;
    logic [1:0] slot;
    logic       slotLast;
    logic       frameEnd;
    logic       load;
    logic       timerClr;
    logic       timerRun;
    logic       sending;

    slot_timer #(.DWELL(DWELL)) uTimer (
        .iClk   (iClk),
        .iRst   (iRst),
        .iClear (timerClr),
        .iRun   (timerRun),
        .oSlot  (slot),
        .oLast  (slotLast)
    );

    assign frameEnd = slotLast && (slot == 2'(NUM_SLOTS - 1));

    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        load      = 1'b0;
        timerClr  = 1'b0;
        timerRun  = 1'b0;
        case (state)
            IDLE: begin
                timerClr = 1'b1;
                if (bus.iEn) begin
                    load      = 1'b1;
                    nextState = SEND;
                end
            end
            SEND: begin
                timerRun = 1'b1;
                if (frameEnd) begin
                    if (bus.iEn) load      = 1'b1;
                    else         nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // frameStart is set on the same edge that loads a frame, so it marks
    // exactly the first cycle of slot 0.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            frameReg   <= '0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= load;
            if (load) frameReg <= {bus.iD3, bus.iD2, bus.iD1, bus.iD0};
        end
    end

    assign sending    = (state == SEND);
    assign bus.oZ     = sending & frameReg[slot];
    assign bus.oS1    = sending & slot[1];
    assign bus.oS0    = sending & slot[0];
    assign bus.oValid = sending;
    assign bus.oFrame = frameStart;
endmodule

// File: tb/tb_selector41_tdm.sv
// Randomized and directed bench for selector41_tdm at DWELL=4 and DWELL=1,
// checked against a frame-position model and a behavioural de_selector14.
module tb_selector41_tdm;
    logic clk;
    logic rstR;

    selector41_tdm_if bus4 ();
    selector41_tdm_if bus1 ();

    selector41_tdm #(.DWELL(4)) dut4 (.iClk(clk), .iRst(rstR), .bus(bus4));
    selector41_tdm #(.DWELL(1)) dut1 (.iClk(clk), .iRst(rstR), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared  = 0;
    int nMismatch  = 0;

    int         busy [2];
    int         pos  [2];
    logic [3:0] bits [2];
    int         dw   [2];

    task automatic chk(input string tag, input int got, input int exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] deSel(input logic z, input logic s1, input logic s0);
        logic [3:0] r;
        r = 4'b0000;
        r[{s1, s0}] = z;
        return r;
    endfunction

    task automatic checkOne(input int k, input logic z, input logic s1, input logic s0,
                            input logic v, input logic f);
        int         slotE;
        logic       zE;
        logic [3:0] loopE;
        slotE = (busy[k] != 0) ? pos[k] / dw[k] : 0;
        zE    = (busy[k] != 0) ? bits[k][slotE] : 1'b0;
        loopE = (busy[k] != 0) ? (bits[k] & (4'b0001 << slotE)) : 4'b0000;
        chk($sformatf("d%0d_valid", dw[k]), int'(v), busy[k]);
        chk($sformatf("d%0d_slot", dw[k]), int'({s1, s0}), slotE);
        chk($sformatf("d%0d_z", dw[k]), int'(z), int'(zE));
        chk($sformatf("d%0d_frame", dw[k]), int'(f), int'(busy[k] != 0 && pos[k] == 0));
        chk($sformatf("d%0d_loopback", dw[k]), int'(deSel(z, s1, s0)), int'(loopE));
    endtask

    task automatic modelEdge(input int k, input logic rst, input logic en, input logic [3:0] d);
        if (rst) begin
            busy[k] = 0;
            pos[k]  = 0;
            bits[k] = 4'b0000;
        end else if (busy[k] == 0) begin
            if (en) begin
                busy[k] = 1;
                pos[k]  = 0;
                bits[k] = d;
            end
        end else if (pos[k] == 4 * dw[k] - 1) begin
            pos[k] = 0;
            if (en) bits[k] = d;
            else    busy[k] = 0;
        end else begin
            pos[k]++;
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [3:0] d);
        @(negedge clk);
        checkOne(0, bus4.oZ, bus4.oS1, bus4.oS0, bus4.oValid, bus4.oFrame);
        checkOne(1, bus1.oZ, bus1.oS1, bus1.oS0, bus1.oValid, bus1.oFrame);
        rstR     = rst;
        bus4.iEn = en;
        bus4.iD0 = d[0]; bus4.iD1 = d[1]; bus4.iD2 = d[2]; bus4.iD3 = d[3];
        bus1.iEn = en;
        bus1.iD0 = d[0]; bus1.iD1 = d[1]; bus1.iD2 = d[2]; bus1.iD3 = d[3];
        modelEdge(0, rst, en, d);
        modelEdge(1, rst, en, d);
    endtask

    initial begin
        dw[0] = 4;
        dw[1] = 1;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0;
            pos[k]  = 0;
            bits[k] = 4'b0000;
        end
        rstR     = 1'b1;
        bus4.iEn = 1'b0;
        bus4.iD0 = 1'b0; bus4.iD1 = 1'b0; bus4.iD2 = 1'b0; bus4.iD3 = 1'b0;
        bus1.iEn = 1'b0;
        bus1.iD0 = 1'b0; bus1.iD1 = 1'b0; bus1.iD2 = 1'b0; bus1.iD3 = 1'b0;

        repeat (3) step(1'b1, 1'b1, 4'b1111);

        // Single-cycle enable, pattern 1011.
        step(1'b0, 1'b1, 4'b1011);
        repeat (20) step(1'b0, 1'b0, 4'($urandom));

        // Enable held, inputs changed mid-frame.
        repeat (8) step(1'b0, 1'b1, 4'b1011);
        repeat (24) step(1'b0, 1'b1, 4'b0100);
        repeat (20) step(1'b0, 1'b0, 4'b0000);

        // Reset during slot 2, then resume.
        step(1'b0, 1'b1, 4'b1011);
        repeat (9) step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b1111);
        repeat (2) step(1'b0, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b1101);
        repeat (20) step(1'b0, 1'b0, 4'b0000);

        // Pattern 0110 (DWELL=1 instance shows 0,1,1,0 on consecutive cycles).
        step(1'b0, 1'b1, 4'b0110);
        repeat (20) step(1'b0, 1'b0, 4'b0000);

        // Loopback over all sixteen patterns.
        for (int p = 0; p < 16; p++) begin
            step(1'b0, 1'b1, 4'(p));
            repeat (17) step(1'b0, 1'b0, 4'($urandom));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 4'($urandom));
        end
        step(1'b0, 1'b0, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
